bist_mem_responder: RTL

//   Memory-side responder for the on-chip SRAM BIST. Accepts write/read requests from a BIST

---
 rtl/bist_pkg.sv | 30 +++
 rtl/bist_fault_inject.sv | 72 +++++++
 rtl/bist_mem_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types for the SRAM BIST responder: FSM state encoding, fault-table entry,
// parameter bounds and a saturating counter helper.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bist_state_e;

  // Fault addresses are stored at a fixed width so the struct does not depend on ADDR_WIDTH
  localparam int FLT_ADDR_W = 8;

  typedef struct packed {
    logic                  en;
    logic [FLT_ADDR_W-1:0] addr;
    logic [2:0]            bitpos;
    logic                  val;
  } fault_entry_t;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;
  localparam int N_FAULTS_MIN   = 1;
  localparam int N_FAULTS_MAX   = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bist_fault_inject.sv
// Stuck-at fault table plus the per-address bit mask / forced-value lookup.
// Lower table index wins when two enabled entries hit the same address and bit.
module bist_fault_inject
  import bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int N_FAULTS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flt_wr_i,
  input  logic [1:0]            flt_idx_i,
  input  logic                  flt_en_i,
  input  logic [ADDR_WIDTH-1:0] flt_addr_i,
  input  logic [2:0]            flt_bit_i,
  input  logic                  flt_val_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] mask_o,
  output logic [DATA_WIDTH-1:0] force_o
);

  localparam int IDX_W = (N_FAULTS > 1) ? $clog2(N_FAULTS) : 1;

  fault_entry_t table_q [N_FAULTS];
  fault_entry_t table_d [N_FAULTS];
  logic         bit_ok_s;
  logic         unused_idx_s;

  assign bit_ok_s     = ({29'd0, flt_bit_i} < 32'(DATA_WIDTH));
  assign unused_idx_s = &{1'b0, flt_idx_i};

  // Table update: one entry per flt_wr pulse, out-of-range bit positions dropped
  always_comb begin
    for (int i = 0; i < N_FAULTS; i++) begin
      if (flt_wr_i && bit_ok_s &&
          ((N_FAULTS == 1) || (flt_idx_i[IDX_W-1:0] == IDX_W'(i)))) begin
        table_d[i].en     = flt_en_i;
        table_d[i].addr   = FLT_ADDR_W'(flt_addr_i);
        table_d[i].bitpos = flt_bit_i;
        table_d[i].val    = flt_val_i;
      end else begin
        table_d[i] = table_q[i];
      end
    end
  end

  // Fault-table registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FAULTS; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      table_q <= table_d;
    end
  end

  // Mask/force lookup; walking from the top index down lets index 0 override last
  always_comb begin
    mask_o  = '0;
    force_o = '0;
    for (int i = N_FAULTS - 1; i >= 0; i--) begin
      mask_o[table_q[i].bitpos]  = mask_o[table_q[i].bitpos] |
          (table_q[i].en && (table_q[i].addr == FLT_ADDR_W'(addr_i)));
      force_o[table_q[i].bitpos] =
          (table_q[i].en && (table_q[i].addr == FLT_ADDR_W'(addr_i))) ?
          table_q[i].val : force_o[table_q[i].bitpos];
    end
  end

endmodule

// File: rtl/bist_mem_responder.sv
// Memory-side BIST responder: valid/ready request and response channels, programmable
// read latency, stuck-at fault injection on read data and saturating access counters.
module bist_mem_responder
  import bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int N_FAULTS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  flt_wr,
  input  logic [1:0]            flt_idx,
  input  logic                  flt_en,
  input  logic [ADDR_WIDTH-1:0] flt_addr,
  input  logic [2:0]            flt_bit,
  input  logic                  flt_val,
  input  logic                  stat_clr,
  output logic [7:0]            stat_wr_cnt,
  output logic [7:0]            stat_rd_cnt
);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX ||
      N_FAULTS < N_FAULTS_MIN || N_FAULTS > N_FAULTS_MAX) begin : g_param_err
    $error("bist_mem_responder: RD_LATENCY or N_FAULTS out of range");
  end

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  bist_state_e           state_q, state_d;
  logic [2:0]            lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d, force_q, force_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d, valid_q, valid_d;
  logic [7:0]            wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  logic                  acc_s, wr_acc_s, rd_acc_s, cons_s;
  logic [DATA_WIDTH-1:0] lkup_mask_s, lkup_force_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic [DATA_WIDTH-1:0] rd_mask_s, rd_force_s, faulted_s;

  assign acc_s    = req_valid & ready_q;
  assign wr_acc_s = acc_s & req_we;
  assign rd_acc_s = acc_s & ~req_we;
  assign cons_s   = valid_q & rsp_ready;

  bist_fault_inject #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .N_FAULTS  (N_FAULTS)
  ) u_fault (
    .clk       (clk),
    .rst_n     (rst_n),
    .flt_wr_i  (flt_wr),
    .flt_idx_i (flt_idx),
    .flt_en_i  (flt_en),
    .flt_addr_i(flt_addr),
    .flt_bit_i (flt_bit),
    .flt_val_i (flt_val),
    .addr_i    (req_addr),
    .mask_o    (lkup_mask_s),
    .force_o   (lkup_force_s)
  );

  // Fault masks are captured at accept so table writes during WAIT hit only later reads
  assign rd_addr_s  = (state_q == ST_IDLE) ? req_addr : addr_q;
  assign rd_mask_s  = (state_q == ST_IDLE) ? lkup_mask_s : mask_q;
  assign rd_force_s = (state_q == ST_IDLE) ? lkup_force_s : force_q;
  assign faulted_s  = (mem_q[rd_addr_s] & ~rd_mask_s) | (rd_force_s & rd_mask_s);

  // Request/response FSM and latency countdown
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    force_d = force_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_acc_s) begin
          addr_d  = req_addr;
          mask_d  = lkup_mask_s;
          force_d = lkup_force_s;
          lat_d   = 3'(RD_LATENCY - 1);
          state_d = (RD_LATENCY == 1) ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (cons_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next-state: read data frozen on RESP entry, handshakes follow the state
  always_comb begin
    rdata_d = ((state_d == ST_RESP) && (state_q != ST_RESP)) ? faulted_s : rdata_q;
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
    if (stat_clr) begin
      wr_cnt_d = 8'd0;
      rd_cnt_d = 8'd0;
    end else begin
      wr_cnt_d = wr_acc_s ? sat_inc8(wr_cnt_q) : wr_cnt_q;
      rd_cnt_d = cons_s ? sat_inc8(rd_cnt_q) : rd_cnt_q;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lat_q    <= 3'd0;
      addr_q   <= '0;
      mask_q   <= '0;
      force_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      wr_cnt_q <= 8'd0;
      rd_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      force_q  <= force_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Test memory array; deliberately not reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[req_addr] <= req_wdata;
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = valid_q;
  assign rsp_rdata   = rdata_q;
  assign stat_wr_cnt = wr_cnt_q;
  assign stat_rd_cnt = rd_cnt_q;

endmodule
